// File: rtl/wb_regfile.sv
// ============================================================================
//  Module      : wb_regfile
//  Description : Write-back stage register file with same-cycle bypass on both
//                read ports, EX forwarding bus and a retired-instruction count.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [ADDR_W-1:0] reg_write_addr_in,
    input  logic              reg_write_en_in,
    input  logic              mem_to_reg_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [ADDR_W-1:0] wb_addr_out,
    output logic              wb_en_out,
    output logic [31:0]       retired_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       retired_q;
    logic [31:0]       retired_d;
    logic [DATA_W-1:0] wb_data;
    logic              we;

    assign wb_data = mem_to_reg_in ? mem_data_in : alu_result_in;

    // reset gates the write so bypass is also suppressed while in reset
    assign we = reset & valid_in & reg_write_en_in & (reg_write_addr_in != '0);

    assign retired_d = valid_in ? retired_q + 32'd1 : retired_q;

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (we && (rs_addr == reg_write_addr_in)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (we && (rt_addr == reg_write_addr_in)) begin
            rt_data = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            retired_q <= 32'd0;
        end else begin
            if (we) begin
                regs_q[reg_write_addr_in] <= wb_data;
            end
            retired_q <= retired_d;
        end
    end

    assign wb_data_out   = wb_data;
    assign wb_addr_out   = reg_write_addr_in;
    assign wb_en_out     = we;
    assign retired_count = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Self-checking bench for wb_regfile using an expected-value queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [ADDR_W-1:0] reg_write_addr_in;
    logic              reg_write_en_in;
    logic              mem_to_reg_in;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data_out;
    logic [ADDR_W-1:0] wb_addr_out;
    logic              wb_en_out;
    logic [31:0]       retired_count;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_in          (valid_in),
        .mem_data_in       (mem_data_in),
        .alu_result_in     (alu_result_in),
        .reg_write_addr_in (reg_write_addr_in),
        .reg_write_en_in   (reg_write_en_in),
        .mem_to_reg_in     (mem_to_reg_in),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .wb_data_out       (wb_data_out),
        .wb_addr_out       (wb_addr_out),
        .wb_en_out         (wb_en_out),
        .retired_count     (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wbd;
        logic [31:0] wba;
        logic [31:0] wbe;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then update model at posedge.
    task automatic step(input logic rstn, input logic v, input logic en,
                        input logic [4:0] wa, input logic m2r,
                        input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] ra, input logic [4:0] rb);
        exp_t        e;
        exp_t        g;
        logic        m_we;
        logic [31:0] m_wbd;
        @(negedge clk);
        reset = rstn; valid_in = v; reg_write_en_in = en; reg_write_addr_in = wa;
        mem_to_reg_in = m2r; mem_data_in = mem; alu_result_in = alu;
        rs_addr = ra; rt_addr = rb;
        m_wbd = m2r ? mem : alu;
        m_we  = rstn && v && en && (wa != 5'd0);
        e.rs  = (ra == 5'd0) ? 32'd0 : (m_we && ra == wa) ? m_wbd : m_regs[ra];
        e.rt  = (rb == 5'd0) ? 32'd0 : (m_we && rb == wa) ? m_wbd : m_regs[rb];
        e.wbd = m_wbd;
        e.wba = {27'd0, wa};
        e.wbe = {31'd0, m_we};
        e.cnt = m_cnt;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        chk("rs_data",       rs_data,              g.rs);
        chk("rt_data",       rt_data,              g.rt);
        chk("wb_data_out",   wb_data_out,          g.wbd);
        chk("wb_addr_out",   {27'd0, wb_addr_out}, g.wba);
        chk("wb_en_out",     {31'd0, wb_en_out},   g.wbe);
        chk("retired_count", retired_count,        g.cnt);
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (m_we) m_regs[wa] = m_wbd;
            if (v) m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        reset = 1'b0; valid_in = 1'b0; reg_write_en_in = 1'b0; reg_write_addr_in = '0;
        mem_to_reg_in = 1'b0; mem_data_in = '0; alu_result_in = '0; rs_addr = '0; rt_addr = '0;

        // Reset with a coincident write attempt, then check reset state
        step(1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 32'h0, 32'h1111_1111, 5'd7, 5'd7);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd1);
        chk("reset_cnt", retired_count, 32'd0);

        // Load to r21, read back next cycle
        step(1'b1, 1'b1, 1'b1, 5'd21, 1'b1, 32'hA5A5_A5A5, 32'h0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd21, 5'd0);
        chk("r21_read", rs_data, 32'hA5A5_A5A5);
        chk("cnt_after_one", retired_count, 32'd1);

        // Same-cycle bypass on both ports
        step(1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 32'h0, 32'h5A5A_5A5A, 5'd10, 5'd10);
        step(1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd10);
        chk("r0_reads_zero", rs_data, 32'd0);
        chk("r0_no_wb_en", {31'd0, wb_en_out}, 32'd0);

        // Invalid slot: no write, no count
        step(1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h1234_5678, 5'd5, 5'd5);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd21);
        chk("r5_unchanged", rs_data, 32'd0);
        chk("cnt_after_invalid", retired_count, 32'd3);

        // Back-to-back writes to the same register
        step(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0000_0001, 5'd9, 5'd9);
        step(1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 32'h0000_0002, 32'h0, 5'd9, 5'd8);
        step(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9);
        chk("b2b_later_wins", rt_data, 32'h0000_0002);

        // r3 written, then reset with coincident write to r4
        step(1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0, 32'hCAFE_F00D, 5'd3, 5'd4);
        chk("rst_wb_en_low", {31'd0, wb_en_out}, 32'd0);
        chk("rst_no_bypass", rt_data, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd4);
        chk("r3_cleared", rs_data, 32'd0);
        chk("r4_dropped", rt_data, 32'd0);
        chk("cnt_cleared", retired_count, 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
                 5'($urandom), 1'($urandom), $urandom, $urandom,
                 5'($urandom), 5'($urandom));
        end

        // Counter wrap via preload
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;
        dut.retired_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
        chk("cnt_wrap", retired_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
